// File: rtl/color_highlight_pipe.sv
// Three-stage colour-highlight pipe: pixels dominated by the selected primary are
// replaced by their luma grey level, and replaced pixels are counted per frame.
module color_highlight_pipe #(
  parameter int DW    = 8,
  parameter int CNT_W = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        ctrl,
  input  logic [3*DW-1:0]   thresh,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic [DW-1:0]     in_r,
  input  logic [DW-1:0]     in_g,
  input  logic [DW-1:0]     in_b,
  output logic              out_valid,
  output logic              out_sop,
  output logic [DW-1:0]     out_r,
  output logic [DW-1:0]     out_g,
  output logic [DW-1:0]     out_b,
  output logic [CNT_W-1:0]  hit_count,
  output logic              frame_done
);

  // One bit of headroom over the score range keeps the signed compare simple.
  localparam int SW = 3*DW + 3;
  localparam int LW = DW + 8;
  localparam logic [1:0] MODE_BYPASS = 2'b11;

  // Stage 1 registers
  logic                 s1_valid_q, s1_valid_d, s1_sop_q, s1_sop_d;
  logic [1:0]           s1_mode_q, s1_mode_d;
  logic [3*DW-1:0]      s1_thresh_q, s1_thresh_d;
  logic [DW-1:0]        s1_r_q, s1_r_d, s1_g_q, s1_g_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic signed [DW:0]   s1_da_q, s1_da_d, s1_db_q, s1_db_d;
  logic [LW-1:0]        s1_lr_q, s1_lr_d, s1_lg_q, s1_lg_d, s1_lb_q, s1_lb_d;

  // Stage 2 registers
  logic                 s2_valid_q, s2_valid_d, s2_sop_q, s2_sop_d;
  logic [1:0]           s2_mode_q, s2_mode_d;
  logic [3*DW-1:0]      s2_thresh_q, s2_thresh_d;
  logic [DW-1:0]        s2_r_q, s2_r_d, s2_g_q, s2_g_d, s2_b_q, s2_b_d, s2_c_q, s2_c_d;
  logic signed [2*DW+1:0] s2_pd_q, s2_pd_d;
  logic [LW-1:0]        s2_luma_q, s2_luma_d;

  // Stage 3 / output and frame counter registers
  logic                 out_valid_q, out_valid_d, out_sop_q, out_sop_d;
  logic [DW-1:0]        out_r_q, out_r_d, out_g_q, out_g_d, out_b_q, out_b_d;
  logic [CNT_W-1:0]     hit_count_q, hit_count_d, acc_q, acc_d;
  logic                 frame_done_q, frame_done_d, seen_q, seen_d;

  logic [DW-1:0]        c_sel, a_sel, b_sel;
  logic signed [SW-1:0] c_ext, pd_ext, thr_ext, score;
  logic [DW-1:0]        gs;
  logic                 hit;

  always_comb begin
    c_sel = in_b;
    a_sel = in_r;
    b_sel = in_g;
    case (ctrl)
      2'b00:   begin c_sel = in_r; a_sel = in_g; b_sel = in_b; end
      2'b01:   begin c_sel = in_g; a_sel = in_r; b_sel = in_b; end
      default: begin c_sel = in_b; a_sel = in_r; b_sel = in_g; end
    endcase

    s1_valid_d  = in_valid;
    s1_sop_d    = in_valid & in_sop;
    s1_mode_d   = ctrl;
    s1_thresh_d = thresh;
    s1_r_d      = in_r;
    s1_g_d      = in_g;
    s1_b_d      = in_b;
    s1_c_d      = c_sel;
    s1_da_d     = $signed({1'b0, c_sel}) - $signed({1'b0, a_sel});
    s1_db_d     = $signed({1'b0, c_sel}) - $signed({1'b0, b_sel});
    s1_lr_d     = LW'(77)  * LW'(in_r);
    s1_lg_d     = LW'(150) * LW'(in_g);
    s1_lb_d     = LW'(29)  * LW'(in_b);
  end

  always_comb begin
    s2_valid_d  = s1_valid_q;
    s2_sop_d    = s1_sop_q;
    s2_mode_d   = s1_mode_q;
    s2_thresh_d = s1_thresh_q;
    s2_r_d      = s1_r_q;
    s2_g_d      = s1_g_q;
    s2_b_d      = s1_b_q;
    s2_c_d      = s1_c_q;
    s2_pd_d     = s1_da_q * s1_db_q;
    s2_luma_d   = s1_lr_q + s1_lg_q + s1_lb_q;
  end

  always_comb begin
    c_ext   = SW'($signed({1'b0, s2_c_q}));
    pd_ext  = SW'(s2_pd_q);
    thr_ext = $signed(SW'(s2_thresh_q));
    score   = c_ext * pd_ext;
    gs      = s2_luma_q[LW-1:8];
    hit     = s2_valid_q && (s2_mode_q != MODE_BYPASS) && (score > thr_ext);

    out_valid_d  = s2_valid_q;
    out_sop_d    = s2_valid_q & s2_sop_q;
    out_r_d      = out_r_q;
    out_g_d      = out_g_q;
    out_b_d      = out_b_q;
    hit_count_d  = hit_count_q;
    acc_d        = acc_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;

    if (s2_valid_q) begin
      out_r_d = hit ? gs : s2_r_q;
      out_g_d = hit ? gs : s2_g_q;
      out_b_d = hit ? gs : s2_b_q;
      if (s2_sop_q) begin
        // The first sop after reset has no preceding frame to report.
        if (seen_q) begin
          hit_count_d  = acc_q;
          frame_done_d = 1'b1;
        end
        acc_d  = CNT_W'(hit);
        seen_d = 1'b1;
      end else if (hit && (acc_q != {CNT_W{1'b1}})) begin
        acc_d = acc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;  s1_sop_q <= 1'b0;  s1_mode_q <= '0;  s1_thresh_q <= '0;
      s1_r_q <= '0;  s1_g_q <= '0;  s1_b_q <= '0;  s1_c_q <= '0;
      s1_da_q <= '0;  s1_db_q <= '0;  s1_lr_q <= '0;  s1_lg_q <= '0;  s1_lb_q <= '0;
      s2_valid_q <= 1'b0;  s2_sop_q <= 1'b0;  s2_mode_q <= '0;  s2_thresh_q <= '0;
      s2_r_q <= '0;  s2_g_q <= '0;  s2_b_q <= '0;  s2_c_q <= '0;
      s2_pd_q <= '0;  s2_luma_q <= '0;
      out_valid_q <= 1'b0;  out_sop_q <= 1'b0;
      out_r_q <= '0;  out_g_q <= '0;  out_b_q <= '0;
      hit_count_q <= '0;  acc_q <= '0;  frame_done_q <= 1'b0;  seen_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;  s1_sop_q <= s1_sop_d;  s1_mode_q <= s1_mode_d;
      s1_thresh_q <= s1_thresh_d;
      s1_r_q <= s1_r_d;  s1_g_q <= s1_g_d;  s1_b_q <= s1_b_d;  s1_c_q <= s1_c_d;
      s1_da_q <= s1_da_d;  s1_db_q <= s1_db_d;
      s1_lr_q <= s1_lr_d;  s1_lg_q <= s1_lg_d;  s1_lb_q <= s1_lb_d;
      s2_valid_q <= s2_valid_d;  s2_sop_q <= s2_sop_d;  s2_mode_q <= s2_mode_d;
      s2_thresh_q <= s2_thresh_d;
      s2_r_q <= s2_r_d;  s2_g_q <= s2_g_d;  s2_b_q <= s2_b_d;  s2_c_q <= s2_c_d;
      s2_pd_q <= s2_pd_d;  s2_luma_q <= s2_luma_d;
      out_valid_q <= out_valid_d;  out_sop_q <= out_sop_d;
      out_r_q <= out_r_d;  out_g_q <= out_g_d;  out_b_q <= out_b_d;
      hit_count_q <= hit_count_d;  acc_q <= acc_d;
      frame_done_q <= frame_done_d;  seen_q <= seen_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_sop    = out_sop_q;
  assign out_r      = out_r_q;
  assign out_g      = out_g_q;
  assign out_b      = out_b_q;
  assign hit_count  = hit_count_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_color_highlight_pipe.sv
// Scoreboard bench for color_highlight_pipe: a second instance with a 2-bit
// counter shares the stimulus so counter saturation is exercised too.
module tb_color_highlight_pipe;
  localparam int DW = 8;
  localparam longint MAX22 = (64'd1 << 22) - 1;
  localparam longint MAX2  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] ctrl = '0;
  logic [3*DW-1:0] thresh = '0;
  logic in_valid = 1'b0, in_sop = 1'b0;
  logic [DW-1:0] in_r = '0, in_g = '0, in_b = '0;

  logic out_valid, out_sop, frame_done;
  logic [DW-1:0] out_r, out_g, out_b;
  logic [21:0] hit_count;
  logic out_valid2, out_sop2, frame_done2;
  logic [DW-1:0] out_r2, out_g2, out_b2;
  logic [1:0] hit_count2;

  color_highlight_pipe #(.DW(DW), .CNT_W(22)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .thresh(thresh),
    .in_valid(in_valid), .in_sop(in_sop), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_sop(out_sop), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .hit_count(hit_count), .frame_done(frame_done));

  color_highlight_pipe #(.DW(DW), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .thresh(thresh),
    .in_valid(in_valid), .in_sop(in_sop), .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid2), .out_sop(out_sop2), .out_r(out_r2), .out_g(out_g2), .out_b(out_b2),
    .hit_count(hit_count2), .frame_done(frame_done2));

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned cyc;
    longint r, g, b;
    bit sop, fd;
    longint hc, hc2;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Frame-count model: true hit count of the open frame, clipped when reported.
  bit     seen_m = 0;
  longint cnt_m = 0, hc_m = 0, hc2_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint min2(input longint x, input longint y);
    return (x < y) ? x : y;
  endfunction

  task automatic drive(input bit v, input bit s, input logic [1:0] m, input longint t,
                       input longint r, input longint g, input longint b);
    exp_t e;
    longint c, a, o, gs;
    bit hit;
    @(posedge clk); #1;
    in_valid = v; in_sop = s; ctrl = m; thresh = t[3*DW-1:0];
    in_r = r[DW-1:0]; in_g = g[DW-1:0]; in_b = b[DW-1:0];
    if (v) begin
      case (m)
        2'b00:   begin c = r; a = g; o = b; end
        2'b01:   begin c = g; a = r; o = b; end
        default: begin c = b; a = r; o = g; end
      endcase
      hit = (m != 2'b11) && (c * (c - a) * (c - o) > t);
      gs  = (77 * r + 150 * g + 29 * b) / 256;
      e.cyc = cyc + 3;
      e.r = hit ? gs : r;
      e.g = hit ? gs : g;
      e.b = hit ? gs : b;
      e.sop = s;
      e.fd = 0;
      if (s) begin
        if (seen_m) begin
          e.fd  = 1;
          hc_m  = min2(cnt_m, MAX22);
          hc2_m = min2(cnt_m, MAX2);
        end
        cnt_m  = hit ? 1 : 0;
        seen_m = 1;
      end else begin
        cnt_m += hit ? 1 : 0;
      end
      e.hc = hc_m;
      e.hc2 = hc2_m;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      drive(0, i[0], 2'($urandom_range(0, 3)), $urandom_range(0, 1000), 200, 0, 0);
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_valid", {out_valid, out_valid2}, 0);
    chk("rst_out_sop", {out_sop, out_sop2}, 0);
    chk("rst_frame_done", {frame_done, frame_done2}, 0);
    chk("rst_pixel", {out_r, out_g, out_b, out_r2, out_g2, out_b2}, 0);
    chk("rst_hit_count", {hit_count, hit_count2}, 0);
    q.delete();
    seen_m = 0; cnt_m = 0; hc_m = 0; hc2_m = 0;
    repeat (hold) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: pops one expectation per valid output, independent of stimulus.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (out_valid || out_valid2) begin
          if (q.size() == 0) begin
            chk("unexpected_valid", {out_valid, out_valid2}, 0);
          end else begin
            e = q.pop_front();
            chk("valid_pair", {out_valid, out_valid2}, 2'b11);
            chk("latency", cyc, e.cyc);
            chk("out_r", out_r, e.r);
            chk("out_g", out_g, e.g);
            chk("out_b", out_b, e.b);
            chk("out_rgb2", {out_r2, out_g2, out_b2}, {e.r[7:0], e.g[7:0], e.b[7:0]});
            chk("out_sop", {out_sop, out_sop2}, {e.sop, e.sop});
            chk("frame_done", {frame_done, frame_done2}, {e.fd, e.fd});
            chk("hit_count", hit_count, e.hc);
            chk("hit_count_sat2", hit_count2, e.hc2);
            $display("txn t=%0t rgb=(%0d,%0d,%0d) sop=%0b fd=%0b hc=%0d hc2=%0d",
                     $time, out_r, out_g, out_b, out_sop, frame_done, hit_count, hit_count2);
          end
        end else begin
          chk("idle_frame_done", {frame_done, frame_done2}, 0);
        end
      end
    end
  end

  initial begin
    int waited;
    do_reset(3);

    // Single-pixel score, bypass and threshold-boundary cases
    drive(1, 1, 2'b00, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b01, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b11, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b00, 8000000, 200, 0, 0);
    drive(1, 0, 2'b00, 7999999, 200, 0, 0);
    drive(1, 0, 2'b00, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b11, 'h0143DA, 200, 0, 0);
    idle(2);
    drive(1, 0, 2'b10, 0, 10, 20, 255);
    idle(4);

    // Frame counting from a clean reset, then 2-bit saturation
    do_reset(2);
    drive(1, 1, 2'b00, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b00, 'h0143DA, 200, 0, 0);
    drive(1, 0, 2'b00, 'h0143DA, 0, 0, 0);
    drive(1, 0, 2'b00, 'h0143DA, 10, 200, 30);
    drive(1, 1, 2'b00, 'h0143DA, 200, 0, 0);
    drive(1, 1, 2'b00, 'h0143DA, 5, 5, 5);
    drive(1, 1, 2'b10, 0, 0, 0, 99);
    for (int i = 0; i < 5; i++) drive(1, 0, 2'b10, 0, 0, 0, 99);
    drive(1, 1, 2'b11, 0, 1, 2, 3);
    drive(1, 1, 2'b11, 0, 1, 2, 3);
    idle(4);

    // Reset with pixels still inside the pipe
    drive(1, 0, 2'b00, 0, 200, 0, 0);
    drive(1, 0, 2'b00, 0, 100, 50, 0);
    drive(1, 0, 2'b01, 0, 0, 250, 3);
    do_reset(2);
    idle(5);
    drive(1, 1, 2'b00, 0, 200, 0, 0);
    drive(1, 0, 2'b00, 0, 200, 0, 0);
    drive(1, 1, 2'b00, 0, 200, 0, 0);
    idle(4);

    // Randomised traffic
    for (int i = 0; i < 800; i++) begin
      longint t;
      t = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 255))
                                      : longint'($urandom_range(0, 16777215)) >> $urandom_range(0, 6);
      drive($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)), t,
            $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    end

    in_valid = 1'b0;
    waited = 0;
    while (q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    chk("drain_pending", q.size(), 0);
    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/color_highlight_pipe.md
# color_highlight_pipe

Pipelined, parametrised colour-highlight stage for the camera video path. Per pixel it computes a dominance score for the selected primary (red, green or blue). Pixels whose score exceeds a run-time threshold are replaced by their luma grey level; all others pass unchanged. It also counts replaced pixels per frame and reports the count at each frame boundary. It sits between the camera RGB stream and downstream filter stages, with a fixed 3-cycle latency and no backpressure.

## Interface
- DW, 8: bits per colour channel.
- CNT_W, 22: width of the per-frame hit counter.
- clk  in  1  pixel clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ctrl  in  2  mode: 00 red, 01 green, 10 blue, 11 bypass.
- thresh  in  3*DW  unsigned score threshold.
- in_valid  in  1  input pixel qualifier.
- in_sop  in  1  first pixel of frame; meaningful only with in_valid.
- in_r / in_g / in_b  in  DW each  input pixel.
- out_valid  out  1  output pixel qualifier.
- out_sop  out  1  delayed in_sop.
- out_r / out_g / out_b  out  DW each  output pixel.
- hit_count  out  CNT_W  hits in the last completed frame.
- frame_done  out  1  one-cycle pulse when hit_count updates.

## Operation
- Selected channel c, other two channels a and b.
  - score = c*(c-a)*(c-b), computed signed at 3*DW+2 bits; no overflow is possible.
  - Hit = (score > thresh), strict greater-than; thresh is zero-extended before the compare.
- Luma: gs = (77*r + 150*g + 29*b) >> 8, truncated.
  - Sum width is DW+8 bits.
  - Result is always ≤ 2^DW − 1; for DW=8 the max is 255.
- On a hit the output is (gs, gs, gs); otherwise the input pixel is passed unchanged.
- Bypass (ctrl=11): pixel passes unchanged and never counts as a hit.
- ctrl and thresh are sampled in stage 1 together with the pixel and carried down the pipe. A change therefore affects only pixels entering on or after the change cycle.
- Pipeline stages:
  - S1: register pixel, sop, valid and mode; compute c-a, c-b and the luma partial products.
  - S2: compute (c-a)*(c-b), the luma sum, and pipe thresh.
  - S3: multiply by c, compare, select, register outputs.
- Pipe registers advance every cycle. Bubbles (in_valid=0) propagate as out_valid=0. Data outputs hold their last value during bubbles.
- Hit counter (accumulator acc, saturating at 2^CNT_W − 1):
  - On S3 output with out_valid=1 and out_sop=1:
    - If at least one sop has already been seen since reset: hit_count ← acc and frame_done=1 that cycle.
    - acc ← hit of this pixel (0 or 1), regardless of the above.
  - On S3 output with out_valid=1 and out_sop=0: acc ← acc + hit, saturating.
  - The first sop after reset gives no frame_done, because there is no previous frame.
  - Pixels arriving before any sop still accumulate; their count is reported at the first sop... only if a sop was seen earlier. Otherwise acc is simply restarted, and that count is discarded.

## Timing
- Latency: exactly 3 clk from in_valid sample to out_valid; throughput one pixel per clock.
- frame_done is asserted in the same cycle as the out_valid/out_sop pixel that closes the frame.
- Reset (asynchronous assert, any time including mid-frame):
  - out_valid, out_sop, frame_done = 0.
  - out_r/g/b = 0, hit_count = 0.
  - acc = 0, sop-seen flag = 0, all pipe valids = 0.
  - In-flight pixels are dropped. After deassertion the first output appears 3 cycles after the first sampled in_valid.
- in_sop with in_valid=0 is ignored.
- Back-to-back sops are legal (one-pixel frames); each produces frame_done after the first.

## Test plan
- Red mode, thresh=0x0143DA, pixel (200,0,0): score=8,000,000 → out (60,60,60) exactly 3 cycles later, out_valid=1.
- Same pixel in green mode (score 0) and in bypass → out (200,0,0). Same pixel in red mode with thresh=8,000,000 → unchanged; with thresh=7,999,999 → (60,60,60).
- ctrl toggles 00→11 between consecutive pixels (200,0,0),(200,0,0) → outputs (60,60,60) then (200,0,0). Also check bubbles in between keep out_valid=0.
- Red mode, frame A = sop+3 pixels with 2 hits, then frame B sop (hit) → no frame_done at A's sop; at B's sop frame_done=1 and hit_count=2. Next sop → hit_count=1.
- CNT_W=2, frame of 6 hits followed by a sop → hit_count=3 (saturated).
- Assert rst_n=0 mid-frame with 3 pixels in flight → all outputs 0 immediately, no stray out_valid after release. First post-reset sop → no frame_done.
